lcd_bus_driver: RTL

- Consumes the character/command strobe interface produced by the menu/message generators: wr with dbi for data, dr with direc for commands.
- Converts each strobe into a timed HD44780-style parallel write cycle: lcd_rs, lcd_rw, lcd_e and lcd_db, followed by an execution wait.
- Runs the power-on initialisation sequence itself before accepting traffic.
- Sits between the message FSMs and the LCD pins inside wb_lcd.

---
 rtl/lcd_bus_driver.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/lcd_bus_driver.sv
// HD44780-style parallel bus driver: runs the power-on init sequence, then
// turns wr/dr strobes into timed rs/db/e write cycles with a 1-deep skid.
module lcd_bus_driver #(
  parameter int T_POWERUP = 400000,
  parameter int T_SETUP   = 2,
  parameter int T_EHIGH   = 12,
  parameter int T_HOLD    = 2,
  parameter int T_EXEC    = 1000,
  parameter int T_CLEAR   = 40000,
  parameter int CW        = 20
) (
  input  logic       clk2,
  input  logic       rst,
  input  logic       wr,
  input  logic [7:0] dbi,
  input  logic       dr,
  input  logic [7:0] direc,
  output logic       ready,
  output logic       init_done,
  output logic       overrun,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db
);

  typedef enum logic [2:0] {
    PWR, IDLE, SETUP, EHI, HOLD, WAIT
  } state_t;

  localparam logic [CW-1:0] PWR_END   = CW'(T_POWERUP - 1);
  localparam logic [CW-1:0] SETUP_END = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] EHI_END   = CW'(T_EHIGH - 1);
  localparam logic [CW-1:0] HOLD_END  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] EXEC_END  = CW'(T_EXEC - 1);
  localparam logic [CW-1:0] CLR_END   = CW'(T_CLEAR - 1);

  function automatic logic [7:0] init_byte(input logic [2:0] i);
    case (i)
      3'd3:    return 8'h0C;
      3'd4:    return 8'h06;
      3'd5:    return 8'h01;
      default: return 8'h38;
    endcase
  endfunction

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          skid_v, skid_v_n;
  logic          skid_rs, skid_rs_n;
  logic [7:0]    skid_db, skid_db_n;
  logic [2:0]    idx, idx_n;
  logic          done_n, ovr_n, ready_n, e_n, rs_n;
  logic [7:0]    db_n;

  logic          req, req_rs;
  logic [7:0]    req_db;
  logic          ld, ld_rs;
  logic [7:0]    ld_db;
  logic          is_clear;
  logic [CW-1:0] wait_end;

  // dr has priority; a simultaneous wr is lost
  assign req    = dr | wr;
  assign req_rs = ~dr;
  assign req_db = dr ? direc : dbi;

  assign is_clear = ~lcd_rs &
    ((lcd_db[7:1] == 7'd0 & lcd_db[0]) |
     (lcd_db[7:1] == 7'd1));
  assign wait_end = is_clear ? CLR_END : EXEC_END;

  assign lcd_rw = 1'b0;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    skid_v_n  = skid_v;
    skid_rs_n = skid_rs;
    skid_db_n = skid_db;
    idx_n     = idx;
    done_n    = init_done;
    ovr_n     = overrun | (dr & wr);
    rs_n      = lcd_rs;
    db_n      = lcd_db;
    ld        = 1'b0;
    ld_rs     = 1'b0;
    ld_db     = 8'h00;
    unique case (state)
      PWR: begin
        if (cnt == PWR_END) begin
          ld    = 1'b1;
          ld_db = init_byte(3'd0);
        end
      end
      IDLE: begin
        cnt_n = '0;
        if (skid_v) begin
          ld       = 1'b1;
          ld_rs    = skid_rs;
          ld_db    = skid_db;
          skid_v_n = 1'b0;
        end else if (ready && req) begin
          ld    = 1'b1;
          ld_rs = req_rs;
          ld_db = req_db;
        end
      end
      SETUP: begin
        if (cnt == SETUP_END) begin
          state_n = EHI;
          cnt_n   = '0;
        end
      end
      EHI: begin
        if (cnt == EHI_END) begin
          state_n = HOLD;
          cnt_n   = '0;
        end
      end
      HOLD: begin
        if (cnt == HOLD_END) begin
          state_n = WAIT;
          cnt_n   = '0;
        end
      end
      WAIT: begin
        if (cnt == wait_end) begin
          cnt_n = '0;
          if (init_done || idx == 3'd5) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            idx_n = idx + 3'd1;
            ld    = 1'b1;
            ld_db = init_byte(idx + 3'd1);
          end
        end
      end
      default: state_n = PWR;
    endcase

    if (ld) begin
      state_n = SETUP;
      cnt_n   = '0;
      rs_n    = ld_rs;
      db_n    = ld_db;
    end

    // not ready: park in the skid, or drop if it is occupied
    if (req && !ready) begin
      if (!skid_v) begin
        skid_v_n  = 1'b1;
        skid_rs_n = req_rs;
        skid_db_n = req_db;
      end else begin
        ovr_n = 1'b1;
      end
    end

    ready_n = (state_n == IDLE) & done_n & ~skid_v_n;
    e_n     = (state_n == EHI);
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      state     <= PWR;
      cnt       <= '0;
      skid_v    <= 1'b0;
      skid_rs   <= 1'b0;
      skid_db   <= 8'h00;
      idx       <= 3'd0;
      init_done <= 1'b0;
      overrun   <= 1'b0;
      ready     <= 1'b0;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_db    <= 8'h00;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      skid_v    <= skid_v_n;
      skid_rs   <= skid_rs_n;
      skid_db   <= skid_db_n;
      idx       <= idx_n;
      init_done <= done_n;
      overrun   <= ovr_n;
      ready     <= ready_n;
      lcd_e     <= e_n;
      lcd_rs    <= rs_n;
      lcd_db    <= db_n;
    end
  end

endmodule
